// File: rtl/fetch_buf_pkg.sv
// Shared types and helpers for the fetch-to-decode instruction buffer.
// One entry holds an instruction word, its pc and its sequence number.
package fetch_buf_pkg;

    // Sequence-number width carried on the fetch/decode interface.
    localparam int SEQ_NUM_BITS = 8;

    typedef struct packed {
        logic [31:0]             inst;
        logic [31:0]             pc;
        logic [SEQ_NUM_BITS-1:0] seq_num;
    } fetch_buf_entry_t;

    // Width of a pointer that indexes 0..depth-1 (at least one bit).
    function automatic int ptr_bits(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fetch_buf_ptr.sv
// Wrap-around pointer register for the fetch buffer.
// Counts 0..p_depth-1 with an explicit wrap compare, so any depth works.
module fetch_buf_ptr
    import fetch_buf_pkg::*;
#(
    parameter int p_depth = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         incr,
    output logic [ptr_bits(p_depth)-1:0] ptr
);

    localparam int PW = ptr_bits(p_depth);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;

    // Next pointer value: hold, advance, or wrap back to zero.
    always_comb begin
        ptr_next = ptr_reg;
        if (incr) begin
            if (ptr_reg == PW'(p_depth - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = ptr_reg + 1'b1;
            end
        end
    end

    // Pointer register; reset and clear both return it to entry 0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/fetch_decode_buffer.sv
// Decoupling FIFO between fetch and decode with val/rdy on both sides.
// Flush discards all entries at the next edge; reset does the same.
// Optional: define FETCH_DECODE_BUFFER_BYPASS_EN for a zero-latency
// pass-through path when the buffer is empty.
// p_seq_num_bits must match fetch_buf_pkg::SEQ_NUM_BITS (the stored entry
// type is fixed by the package).
module fetch_decode_buffer
    import fetch_buf_pkg::*;
#(
    parameter int p_depth        = 4,
    parameter int p_seq_num_bits = SEQ_NUM_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         f_val,
    output logic                         f_rdy,
    input  logic [31:0]                  f_inst,
    input  logic [31:0]                  f_pc,
    input  logic [p_seq_num_bits-1:0]    f_seq_num,
    output logic                         d_val,
    input  logic                         d_rdy,
    output logic [31:0]                  d_inst,
    output logic [31:0]                  d_pc,
    output logic [p_seq_num_bits-1:0]    d_seq_num,
    output logic [$clog2(p_depth+1)-1:0] count
);

    localparam int PW = ptr_bits(p_depth);
    localparam int CW = $clog2(p_depth + 1);

    fetch_buf_entry_t mem [p_depth];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    fetch_buf_entry_t wr_entry;
    fetch_buf_entry_t rd_entry;
    logic             empty;
    logic             full;
    logic             enq;
    logic             deq;
    logic             pass;
    logic             mem_wr;
    logic             mem_rd;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(p_depth));
    assign wr_entry = '{inst: f_inst, pc: f_pc, seq_num: f_seq_num};
    assign rd_entry = mem[rd_ptr];

    // Handshake outputs and head payload; flush blocks both sides.
    always_comb begin
        f_rdy     = !full && !flush;
        d_val     = !empty && !flush;
        d_inst    = rd_entry.inst;
        d_pc      = rd_entry.pc;
        d_seq_num = rd_entry.seq_num;
        pass      = 1'b0;
`ifdef FETCH_DECODE_BUFFER_BYPASS_EN
        if (empty && !flush) begin
            f_rdy     = 1'b1;
            d_val     = f_val;
            d_inst    = f_inst;
            d_pc      = f_pc;
            d_seq_num = f_seq_num;
            pass      = f_val && d_rdy;
        end
`endif
    end

    assign enq    = f_val && f_rdy;
    assign deq    = d_val && d_rdy;
    // A pass-through transfer never touches storage.
    assign mem_wr = enq && !pass;
    assign mem_rd = deq && !pass;

    // Occupancy follows storage writes and reads only.
    always_comb begin
        count_next = count_reg;
        if (mem_wr && !mem_rd) begin
            count_next = count_reg + 1'b1;
        end else if (mem_rd && !mem_wr) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Occupancy register; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (mem_wr && !rst) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    fetch_buf_ptr #(.p_depth(p_depth)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .incr  (mem_wr),
        .ptr   (wr_ptr)
    );

    fetch_buf_ptr #(.p_depth(p_depth)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .incr  (mem_rd),
        .ptr   (rd_ptr)
    );

    assign count = count_reg;

`ifndef SYNTHESIS
    // Structural invariants of the FIFO bookkeeping.
    a_count_max : assert property (@(posedge clk) disable iff (rst)
        count_reg <= CW'(p_depth));
    a_no_enq_full : assert property (@(posedge clk) disable iff (rst)
        !(mem_wr && full));
    a_no_deq_empty : assert property (@(posedge clk) disable iff (rst)
        !(mem_rd && empty));

    // Fixed-width trace: enq pc | count | deq seq_num:pc.
    function automatic string line_trace();
        string enq_s;
        string deq_s;
        enq_s = enq ? $sformatf("%08h", f_pc) : "        ";
        deq_s = deq ? $sformatf("%02h:%08h", d_seq_num, d_pc) : "           ";
        return $sformatf("%s|%2d|%s", enq_s, count_reg, deq_s);
    endfunction
`endif

endmodule
